// File: rtl/clk_tick_pkg.sv
// -----------------------------------------------------------------------------
// clk_tick_pkg
// Shared definitions for the fractional clock-enable generator:
//   - clk_tick_state_e : generator FSM states (SETTLE / RUN / APPLY)
//   - DEF_NUM_CH / DEF_ACC_W : default channel count and accumulator width
//   - calc_incr()      : increment needed for a target tick rate, for callers
//                        and benches that want to program cfg_incr
// -----------------------------------------------------------------------------
package clk_tick_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_ACC_W  = 24;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_RUN    = 2'd1,
        ST_APPLY  = 2'd2
    } clk_tick_state_e;

    // Rounded increment: incr = tgt_hz * 2^acc_w / clk_hz.
    // A zero clock frequency yields a zero increment (channel stays silent).
    function automatic logic [63:0] calc_incr(
        input logic [63:0] clk_hz,
        input logic [63:0] tgt_hz,
        input int unsigned acc_w
    );
        logic [63:0] num_s;
        if (clk_hz == 64'd0) begin
            return 64'd0;
        end else begin
            num_s = (tgt_hz << acc_w) + (clk_hz >> 1);
            return num_s / clk_hz;
        end
    endfunction

endpackage

// File: rtl/clk_tick_acc.sv
// -----------------------------------------------------------------------------
// clk_tick_acc
// One tick channel: an ACC_W-bit phase accumulator plus a registered carry.
// While `run` is high the accumulator adds `incr` every cycle and the carry
// out of that add becomes the tick one cycle later. `load` has priority and
// forces the accumulator to `load_val` (zero or a phase offset). With neither
// asserted the accumulator holds and the tick is forced low.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   run       in   advance the accumulator this cycle
//   load      in   load accumulator with load_val this cycle
//   incr      in   [ACC_W] phase increment
//   load_val  in   [ACC_W] value loaded when load is high
//   tick      out  registered carry of the previous add
// -----------------------------------------------------------------------------
module clk_tick_acc #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [ACC_W-1:0] incr,
    input  logic [ACC_W-1:0] load_val,
    output logic             tick
);

    logic [ACC_W-1:0] acc_r;
    logic             tick_r;
    logic [ACC_W:0]   sum_s;

    // Wrapping add computed one bit wider so the carry is the tick source.
    always_comb begin
        sum_s = {1'b0, acc_r} + {1'b0, incr};
    end

    // Accumulator and tick register: load beats run, idle holds and silences.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= {ACC_W{1'b0}};
            tick_r <= 1'b0;
        end else if (load) begin
            acc_r  <= load_val;
            tick_r <= 1'b0;
        end else if (run) begin
            acc_r  <= sum_s[ACC_W-1:0];
            tick_r <= sum_s[ACC_W];
        end else begin
            acc_r  <= acc_r;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/clk_tick_gen.sv
// -----------------------------------------------------------------------------
// clk_tick_gen
// Multi-channel fractional clock-enable generator. Each of NUM_CH channels
// owns a phase accumulator (clk_tick_acc) whose carry produces single-cycle
// tick enables at a rate of incr / 2^ACC_W per clock. A shared FSM provides a
// `locked` status: after reset or any accepted reconfiguration the generator
// settles for LOCK_CYCLES cycles with all ticks silenced, then runs.
//
// Optional feature (macro CLK_TICK_PHASE_EN): adds input cfg_phase; on a
// reconfiguration the target channel's accumulator is preloaded with
// cfg_phase while every other channel restarts at zero, giving programmable
// relative phase. Without the macro every accumulator restarts at zero.
//
// Ports:
//   clk_in1    in   system clock
//   reset_n    in   asynchronous active-low reset
//   cfg_valid  in   configuration request (requester holds until cfg_ready)
//   cfg_ready  out  configuration accept, high only while running
//   cfg_chan   in   [CH_W] target channel
//   cfg_incr   in   [ACC_W] new increment for the target channel
//   cfg_phase  in   [ACC_W] start phase for target channel (macro only)
//   cfg_err    out  one-cycle pulse when a request names a missing channel
//   tick       out  [NUM_CH] per-channel single-cycle enable pulses
//   locked     out  generator running and all channels aligned
// -----------------------------------------------------------------------------
module clk_tick_gen
    import clk_tick_pkg::*;
#(
    parameter int               NUM_CH       = DEF_NUM_CH,
    parameter int               ACC_W        = DEF_ACC_W,
    parameter int               LOCK_CYCLES  = 16,
    parameter logic [ACC_W-1:0] DEFAULT_INCR = 24'h0A3D71,
    localparam int              CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in1,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_chan,
    input  logic [ACC_W-1:0]  cfg_incr,
`ifdef CLK_TICK_PHASE_EN
    input  logic [ACC_W-1:0]  cfg_phase,
`endif
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic              locked
);

    localparam int              CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    // Channel count widened by one bit so indices >= NUM_CH are comparable.
    localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);

    clk_tick_state_e  state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             locked_r;
    logic             cfg_ready_r;
    logic             cfg_err_r;
    logic [CH_W-1:0]  chan_r;
    logic [ACC_W-1:0] new_incr_r;
    logic [ACC_W-1:0] incr_r [NUM_CH];
`ifdef CLK_TICK_PHASE_EN
    logic [ACC_W-1:0] phase_r;
`endif

    logic              xfer_s;
    logic              chan_ok_s;
    logic              run_s;
    logic              load_s;
    logic [NUM_CH-1:0] tick_s;

    // Handshake decode; cfg_ready_r is only high in RUN so xfer implies RUN.
    always_comb begin
        xfer_s = cfg_valid && cfg_ready_r;
        if ({1'b0, cfg_chan} < NUM_CH_V) begin
            chan_ok_s = 1'b1;
        end else begin
            chan_ok_s = 1'b0;
        end
    end

    // Accumulator controls derived from the current state.
    always_comb begin
        run_s  = (state_r == ST_RUN);
        load_s = (state_r == ST_APPLY);
    end

    // Relock FSM, status outputs and the configuration write path.
    always_ff @(posedge clk_in1 or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_SETTLE;
            cnt_r       <= {CNT_W{1'b0}};
            locked_r    <= 1'b0;
            cfg_ready_r <= 1'b0;
            cfg_err_r   <= 1'b0;
            chan_r      <= {CH_W{1'b0}};
            new_incr_r  <= {ACC_W{1'b0}};
`ifdef CLK_TICK_PHASE_EN
            phase_r     <= {ACC_W{1'b0}};
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                incr_r[i] <= DEFAULT_INCR;
            end
        end else begin
            case (state_r)
                ST_SETTLE: begin
                    cfg_err_r <= 1'b0;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r       <= {CNT_W{1'b0}};
                        state_r     <= ST_RUN;
                        locked_r    <= 1'b1;
                        cfg_ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (xfer_s && chan_ok_s) begin
                        // The add in this cycle still produces its tick;
                        // the accumulators are silenced from APPLY onward.
                        state_r     <= ST_APPLY;
                        locked_r    <= 1'b0;
                        cfg_ready_r <= 1'b0;
                        cfg_err_r   <= 1'b0;
                        chan_r      <= cfg_chan;
                        new_incr_r  <= cfg_incr;
`ifdef CLK_TICK_PHASE_EN
                        phase_r     <= cfg_phase;
`endif
                    end else if (xfer_s) begin
                        // Bad index: reject, keep running undisturbed.
                        cfg_err_r <= 1'b1;
                    end else begin
                        cfg_err_r <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    cfg_err_r <= 1'b0;
                    cnt_r     <= {CNT_W{1'b0}};
                    state_r   <= ST_SETTLE;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (chan_r == CH_W'(i)) begin
                            incr_r[i] <= new_incr_r;
                        end else begin
                            incr_r[i] <= incr_r[i];
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: recover through a full relock.
                    state_r     <= ST_SETTLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    locked_r    <= 1'b0;
                    cfg_ready_r <= 1'b0;
                    cfg_err_r   <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [ACC_W-1:0] load_val_s;

`ifdef CLK_TICK_PHASE_EN
        // Only the reconfigured channel starts at its programmed phase.
        always_comb begin
            if (chan_r == CH_W'(gi)) begin
                load_val_s = phase_r;
            end else begin
                load_val_s = {ACC_W{1'b0}};
            end
        end
`else
        assign load_val_s = {ACC_W{1'b0}};
`endif

        clk_tick_acc #(
            .ACC_W (ACC_W)
        ) u_acc (
            .clk      (clk_in1),
            .rst_n    (reset_n),
            .run      (run_s),
            .load     (load_s),
            .incr     (incr_r[gi]),
            .load_val (load_val_s),
            .tick     (tick_s[gi])
        );
    end

    assign tick      = tick_s;
    assign locked    = locked_r;
    assign cfg_ready = cfg_ready_r;
    assign cfg_err   = cfg_err_r;

endmodule
